// File: rtl/sram_like_arbiter_pkg.sv
//------------------------------------------------------------------------------
// sram_arb_pkg : source IDs and access-size encodings for sram_like_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

endpackage

`default_nettype wire

// File: rtl/sram_like_arbiter_id_fifo.sv
//------------------------------------------------------------------------------
// arb_id_fifo : 1-bit-wide in-order FIFO of request source IDs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
//------------------------------------------------------------------------------
// sram_like_arbiter : shares one sram-like port between inst and data masters.
// Optional macro SRAM_ARB_RR_EN selects round-robin conflict policy. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_win;
  logic w_conf_win;
  logic w_lock_hold;
  logic w_hs;
  logic w_resp;
  logic r_lock_vld;
  logic r_lock_src;

`ifdef SRAM_ARB_RR_EN
  logic r_last;

  // The master passed over at the last handshake wins the next conflict.
  assign w_conf_win = ~r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= SRC_INST;
    end else if (w_hs) begin
      r_last <= w_win;
    end
  end
`else
  assign w_conf_win = SRC_DATA;
`endif

  assign w_lock_hold = r_lock_vld & ((r_lock_src == SRC_INST) ? inst_req : data_req);

  always_comb begin
    w_win = SRC_INST;
    if (w_lock_hold) begin
      w_win = r_lock_src;
    end else if (inst_req && data_req) begin
      w_win = w_conf_win;
    end else if (data_req) begin
      w_win = SRC_DATA;
    end
  end

  // Full blocks the request even on a same-cycle pop, keeping data_ok out of req.
  assign mem_req = (inst_req | data_req) & ~w_full & ~reset;
  assign w_hs    = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    if (!reset) begin
      if (w_win == SRC_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        mem_wstrb = data_wstrb;
      end else begin
        mem_size  = inst_size;
        mem_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok = w_hs & (w_win == SRC_INST);
  assign data_addr_ok = w_hs & (w_win == SRC_DATA);

  assign w_resp       = mem_data_ok & ~w_empty & ~reset;
  assign inst_data_ok = w_resp & (w_head == SRC_INST);
  assign data_data_ok = w_resp & (w_head == SRC_DATA);
  assign inst_rdata   = reset ? 32'd0 : mem_rdata;
  assign data_rdata   = reset ? 32'd0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_vld <= 1'b0;
      r_lock_src <= SRC_INST;
    end else begin
      r_lock_vld <= mem_req & ~mem_addr_ok;
      r_lock_src <= w_win;
    end
  end

  arb_id_fifo #(
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_hs),
    .din   (w_win),
    .pop   (mem_data_ok & ~reset),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
//------------------------------------------------------------------------------
// tb_sram_like_arbiter : directed self-checking bench for sram_like_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_like_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d;
    reset = 1'b1; inst_req = 1'b0; inst_size = 2'd2; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'd0;
    data_wdata = 32'd0; data_wstrb = 4'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    tick(); tick();

    // Reset: every output held at zero even with requests present
    inst_req = 1'b1; inst_addr = 32'hBFC00000; mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    tick();
    reset = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;

    // Single requester, accept after 2 wait cycles
    #1;
    chk("s1_mem_req", mem_req, 1);
    chk("s1_mem_addr", mem_addr, 32'hBFC00000);
    chk("s1_addr_ok_wait0", inst_addr_ok, 0);
    tick(); #1;
    chk("s1_addr_ok_wait1", inst_addr_ok, 0);
    tick(); mem_addr_ok = 1'b1; #1;
    chk("s1_inst_addr_ok", inst_addr_ok, 1);
    chk("s1_data_addr_ok", data_addr_ok, 0);
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b0; #1;
    chk("s1_idle_req", mem_req, 0);
    chk("s1_idle_addr_ok", inst_addr_ok, 0);
    tick(); mem_data_ok = 1'b1; mem_rdata = 32'h3C1D0000; #1;
    chk("s1_inst_data_ok", inst_data_ok, 1);
    chk("s1_inst_rdata", inst_rdata, 32'h3C1D0000);
    chk("s1_data_data_ok", data_data_ok, 0);
    tick(); mem_data_ok = 1'b0;

    // Conflict: 4 handshakes with both requests held
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h400; data_addr = 32'h800;
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_d = RR ? (i % 2 == 0) : 1'b1;
      #1;
      chk($sformatf("conf%0d_data_addr_ok", i), data_addr_ok, exp_d);
      chk($sformatf("conf%0d_inst_addr_ok", i), inst_addr_ok, !exp_d);
      chk($sformatf("conf%0d_mem_addr", i), mem_addr, exp_d ? 32'h800 : 32'h400);
      tick();
    end

    // Full: 5th request blocked, still blocked on the pop cycle, reasserts after
    #1;
    chk("full_mem_req", mem_req, 0);
    chk("full_addr_ok", data_addr_ok | inst_addr_ok, 0);
    tick(); mem_data_ok = 1'b1; mem_rdata = 32'hA0A0A0A0; #1;
    chk("full_pop_mem_req", mem_req, 0);
    chk("full_pop_data_ok", data_data_ok, 1);
    chk("full_pop_data_rdata", data_rdata, 32'hA0A0A0A0);
    tick(); mem_data_ok = 1'b0; mem_addr_ok = 1'b0; #1;
    chk("full_reassert", mem_req, 1);
    tick(); inst_req = 1'b0; data_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      exp_d = RR ? (i % 2 == 0) : 1'b1;
      mem_data_ok = 1'b1; mem_rdata = 32'h100 + i;
      #1;
      chk($sformatf("drain%0d_data_ok", i), data_data_ok, exp_d);
      chk($sformatf("drain%0d_inst_ok", i), inst_data_ok, !exp_d);
      tick();
    end
    mem_data_ok = 1'b0;

    // Grant lock: inst stalls 3 cycles while data rises in cycle 2
    inst_req = 1'b1; inst_addr = 32'h1000; data_addr = 32'h2000; mem_addr_ok = 1'b0;
    #1; chk("lock_c1_addr", mem_addr, 32'h1000);
    tick(); data_req = 1'b1; #1;
    chk("lock_c2_addr", mem_addr, 32'h1000);
    chk("lock_c2_data_ok", data_addr_ok, 0);
    tick(); #1; chk("lock_c3_addr", mem_addr, 32'h1000);
    tick(); mem_addr_ok = 1'b1; #1;
    chk("lock_hs_addr", mem_addr, 32'h1000);
    chk("lock_hs_inst_ok", inst_addr_ok, 1);
    chk("lock_hs_data_ok", data_addr_ok, 0);
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b0; #1;
    chk("lock_after_addr", mem_addr, 32'h2000);
    tick(); data_req = 1'b0; mem_data_ok = 1'b1; #1;
    chk("lock_resp_inst", inst_data_ok, 1);
    tick(); mem_data_ok = 1'b0;

    // Ordering: I, D write, I, D read then 4 responses
    mem_addr_ok = 1'b1; inst_req = 1'b1; inst_addr = 32'h100; #1;
    chk("ord_i0_ok", inst_addr_ok, 1);
    tick(); inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h200;
    data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF; data_size = 2'd2; #1;
    chk("ord_d1_ok", data_addr_ok, 1);
    chk("ord_d1_wr", mem_wr, 1);
    chk("ord_d1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("ord_d1_wstrb", mem_wstrb, 4'hF);
    tick(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h104; #1;
    chk("ord_i2_ok", inst_addr_ok, 1);
    chk("ord_i2_wr", mem_wr, 0);
    chk("ord_i2_wdata", mem_wdata, 0);
    chk("ord_i2_wstrb", mem_wstrb, 0);
    tick(); inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h204;
    data_size = 2'd1; #1;
    chk("ord_d3_ok", data_addr_ok, 1);
    chk("ord_d3_size", mem_size, 2'd1);
    chk("ord_d3_addr", mem_addr, 32'h204);
    tick(); data_req = 1'b0; mem_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_d = (i % 2 == 1);
      mem_data_ok = 1'b1; mem_rdata = 32'h11 * (i + 1);
      #1;
      chk($sformatf("ord_r%0d_data_ok", i), data_data_ok, exp_d);
      chk($sformatf("ord_r%0d_inst_ok", i), inst_data_ok, !exp_d);
      chk($sformatf("ord_r%0d_rdata", i), exp_d ? data_rdata : inst_rdata, 32'h11 * (i + 1));
      tick();
    end
    mem_data_ok = 1'b0;

    // Stray response with empty FIFO is ignored
    mem_data_ok = 1'b1; #1;
    chk("empty_resp_inst", inst_data_ok, 0);
    chk("empty_resp_data", data_data_ok, 0);
    tick(); mem_data_ok = 1'b0;

    // Reset mid-flight: I and D outstanding, then reset discards them
    mem_addr_ok = 1'b1; inst_req = 1'b1; #1;
    chk("rmf_i_ok", inst_addr_ok, 1);
    tick(); inst_req = 1'b0; data_req = 1'b1; #1;
    chk("rmf_d_ok", data_addr_ok, 1);
    tick(); data_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1; mem_data_ok = 1'b1; #1;
    chk("rmf_in_rst_inst", inst_data_ok, 0);
    chk("rmf_in_rst_data", data_data_ok, 0);
    tick(); reset = 1'b0; #1;
    chk("rmf_post_inst", inst_data_ok, 0);
    chk("rmf_post_data", data_data_ok, 0);
    tick(); mem_data_ok = 1'b0; data_req = 1'b1; mem_addr_ok = 1'b1; #1;
    chk("rmf_new_d_ok", data_addr_ok, 1);
    tick(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
    chk("rmf_new_resp_data", data_data_ok, 1);
    chk("rmf_new_resp_inst", inst_data_ok, 0);
    tick(); mem_data_ok = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master arbiter that shares one sram-like memory port between the instruction-fetch master (IF stage) and the data master (EXE stage load/store request, MEM stage response). It sits between the CPU core and the sram-like-to-AXI bridge. It grants one address request per cycle and records the source of every accepted request in an in-order ID FIFO. It routes each returning `data_ok`/`rdata` to the master that issued it.

## Interface
- `DEPTH`, default 4: maximum outstanding accepted-but-unanswered requests (power of two, ≥2).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `inst_req`  in  1  instruction read request (always a read).
- `inst_size`  in  2  instruction access size (0=byte, 1=half, 2=word).
- `inst_addr`  in  32  instruction address.
- `inst_addr_ok`  out  1  instruction request accepted this cycle.
- `inst_data_ok`  out  1  instruction response valid this cycle.
- `inst_rdata`  out  32  instruction response data.
- `data_req`, `data_wr`  in  1 each  data request and write flag.
- `data_size`  in  2  data access size.
- `data_addr`, `data_wdata`  in  32 each  data address and write data.
- `data_wstrb`  in  4  data byte strobes.
- `data_addr_ok`, `data_data_ok`  out  1 each  data request accepted / data response valid.
- `data_rdata`  out  32  data response data.
- `mem_req`, `mem_wr`  out  1 each  request to memory port and its write flag.
- `mem_size`  out  2  size forwarded from the winning master.
- `mem_addr`, `mem_wdata`  out  32 each  address and write data from the winning master.
- `mem_wstrb`  out  4  byte strobes from the winning master.
- `mem_addr_ok`, `mem_data_ok`  in  1 each  port accept / port response.
- `mem_rdata`  in  32  port response data.

## Operation
- The winner is `data` when only `data_req` is high, `inst` when only `inst_req` is high, and set by the arbitration policy (see Configuration) when both are high.
- Grant lock:
  - If `mem_req` was high last cycle and `mem_addr_ok` was low, the locked master keeps the grant while its req stays high.
  - The lock clears on `mem_addr_ok` or when the locked master drops req.
- `mem_req` = (`inst_req` | `data_req`) & !fifo_full & !reset.
- `mem_*` payload is muxed from the winner. For `inst`, `mem_wr`=0, `mem_wstrb`=0, `mem_wdata`=0.
- `<winner>_addr_ok` = `mem_addr_ok` & `mem_req`. The loser's `addr_ok` is 0.
- On handshake (`mem_req` & `mem_addr_ok`), the source ID (0=inst, 1=data) is pushed into the ID FIFO.
- On `mem_data_ok` with the FIFO non-empty, the head ID is popped. `inst_data_ok` or `data_data_ok` follows the head ID.
- `mem_rdata` is broadcast to both `*_rdata`. Write responses also pop and pulse `data_data_ok`.
- `mem_data_ok` with the FIFO empty is a protocol error: ignored, no pop, no master `data_ok`.
- Full: when FIFO count == `DEPTH`, `mem_req`=0 even if a pop occurs the same cycle. This keeps `data_ok` out of the `req` path.
- Simultaneous push and pop when not full: count unchanged, pointers both advance and wrap modulo `DEPTH`.

## Timing
- Request path is combinational, zero latency: master req → `mem_req`, and `mem_addr_ok` → master `addr_ok`.
- Response path is combinational: `mem_data_ok` → master `data_ok` in the same cycle.
- FIFO, lock and round-robin state update at posedge `clk`.
- A response may return the cycle after its push at the earliest. A same-cycle push and response for an empty FIFO is not supported; the port never does this.
- Reset values: FIFO empty (count 0, pointers 0), lock clear, round-robin last-grant = `inst`. All outputs are 0 during `reset`.
- Reset mid-operation discards all outstanding IDs. Responses arriving after reset deassertion are dropped as empty-FIFO responses.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin on conflict. The master not granted at the last completed handshake wins. Last-grant updates on each handshake.
- `SRAM_ARB_RR_EN` undefined: fixed priority, `data` wins every conflict. The round-robin register is not built.
- Grant lock applies in both modes.

## Structure
- Package `sram_arb_pkg`:
  - Source IDs `SRC_INST`=1'b0 and `SRC_DATA`=1'b1.
  - Size encodings `SIZE_B`/`SIZE_H`/`SIZE_W`.
- Sub-module `arb_id_fifo`: 1-bit-wide, `DEPTH`-deep synchronous FIFO with push, pop, head, full and empty outputs. It ignores pop when empty.
- Top level holds the winner select, the grant lock and the round-robin register.

## Test plan
- Single requester: `inst_req`=1, addr 0xBFC00000, `mem_addr_ok` after 2 cycles → `inst_addr_ok` pulses once. Then `mem_data_ok` with rdata 0x3C1D0000 → `inst_data_ok`=1, `inst_rdata`=0x3C1D0000, `data_data_ok`=0.
- Conflict: both reqs held for 4 handshakes. Without the macro, grants are D,D,D,D. With `SRAM_ARB_RR_EN`, grants alternate starting with D.
- Grant lock: `inst` granted with `mem_addr_ok` low for 3 cycles while `data_req` rises in cycle 2 → `mem_addr` stays `inst_addr` until the handshake.
- Ordering: issue I, D(write), I, D(read). Then 4 `mem_data_ok` → `data_ok` pulses route I, D, I, D in order.
- Full: `DEPTH`=4, 4 handshakes with no responses → `mem_req`=0 on the 5th request. One `mem_data_ok` → `mem_req` reasserts the next cycle.
- Reset mid-flight: 2 outstanding, pulse `reset`, then `mem_data_ok` → no master `data_ok`, count stays 0.
